// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding,
// legal WIDTH range and the counter-width helper.
package bit_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Bit counter width: ceil(log2(w)), at least one bit.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_fa_bit.sv
// Purely combinational 1-bit full adder cell.
// Ports: a, b, ci - addend bits and carry in; s - sum bit; co - carry out.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH clocks,
// LSB first, with a start/busy/done handshake.
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   start          - request, accepted in IDLE or DONE
//   a, b, cin      - operands and carry-in, latched on the accepting edge
//   busy           - high while bits are processed
//   done           - one-cycle pulse, results valid from this cycle
//   sum, cout      - registered result and carry out of the MSB
//   overflow       - signed overflow (carry into MSB ^ carry out of MSB)
module bit_serial_adder_ctrl
    import bit_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("bit_serial_adder_ctrl: WIDTH out of legal range 2..32");
    end

    localparam int unsigned     CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             accept, last;
    logic             fa_s, fa_co;

    fa_bit u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Partial sum keeps only the upper WIDTH-1 bits already produced; the
    // full word is formed with the current cell output on the final edge.
    assign psum_next = {fa_s, psum};

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_SHIFT;
                    accept     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST) begin
                    next_state = ST_DONE;
                    last       = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state = ST_SHIFT;
                    accept     = 1'b1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            psum     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa_co;
            psum  <= psum_next[WIDTH-1:1];
            if (last) begin
                // carry still holds the carry into the MSB here
                sum      <= psum_next;
                cout     <= fa_co;
                overflow <= carry ^ fa_co;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
module tb_bit_serial_adder_ctrl;

    localparam int unsigned W  = 8;
    localparam int          WI = W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc = 0;
    int   next_free = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer addition; overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input int due);
        exp_t        e;
        logic [W:0]  full;
        full  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (e.sum[W-1] != av[W-1]);
        e.due  = due;
        return e;
    endfunction

    // Monitor: after each edge, compare handshake and held results.
    initial begin
        forever begin
            logic exp_done, exp_busy;
            @(posedge clk);
            #1;
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            exp_busy = (q.size() > 0) && (cyc >= q[0].due - WI) && (cyc < q[0].due);
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            if (exp_done) held = q.pop_front();
            check("sum", 64'(sum), 64'(held.sum));
            check("cout", 64'(cout), 64'(held.cout));
            check("overflow", 64'(overflow), 64'(held.ovf));
        end
    end

    // One clock of stimulus; the model decides whether start is accepted.
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic r, output logic acc);
        @(negedge clk);
        start = s;
        a     = av;
        b     = bv;
        cin   = ci;
        rst   = r;
        acc   = 1'b0;
        if (r) begin
            q.delete();
            held.sum  = '0;
            held.cout = 1'b0;
            held.ovf  = 1'b0;
            next_free = cyc + 2;
        end else if (s && (cyc + 1 >= next_free)) begin
            q.push_back(model(av, bv, ci, cyc + 1 + WI));
            next_free = cyc + 2 + WI;
            acc = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        logic acc;
        drive(1'b1, av, bv, ci, 1'b0, acc);
        idle(WI);
    endtask

    initial begin
        logic acc;
        int   n;
        held.sum  = '0;
        held.cout = 1'b0;
        held.ovf  = 1'b0;
        held.due  = 0;

        // reset with start high: reset wins
        drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1, acc);
        drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
        idle(2);

        op(8'h0F, 8'h01, 1'b0);
        idle(2);
        op(8'hFF, 8'h01, 1'b0);
        op(8'h7F, 8'h01, 1'b0);
        op(8'h80, 8'h80, 1'b1);
        idle(3);

        // start during SHIFT bit 3 ignored
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, acc);
        idle(3);
        drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, acc);
        idle(WI - 4);
        idle(5);

        // reset during SHIFT bit 5
        drive(1'b1, 8'h5A, 8'h33, 1'b1, 1'b0, acc);
        idle(5);
        drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
        idle(WI + 3);

        // start held high: back-to-back operations
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            if (n == 0) drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, acc);
            else        drive(1'b1, 8'h02, 8'h02, 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        idle(WI + 2);

        // randomized operations with stray starts and occasional resets
        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc);
            for (int j = 0; j < WI; j++) begin
                drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom),
                      1'($urandom), ($urandom_range(0, 80) == 0), acc);
            end
        end

        idle(WI + 3);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
